amiga_dram_ctrl: RTL

- Initiator side of the multiplexed-address DRAM interface used by the daughterboard RAM array (41464-class 64Kx4 parts, two banks x 16 bits).
- Converts a 68000 bus cycle into RAS/row-address, then column-address/CAS timing, and returns _DTACK.
- Schedules RAS-only refresh from an internal 8-bit row counter.
- Sits between the CPU address decode and the DRAM array, its address mux and its data buffers.

---
 rtl/amiga_dram_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/amiga_dram_ctrl.sv
// amiga_dram_ctrl: 68000 bus cycle to multiplexed-address DRAM timing (41464, two banks x16) with RAS-only refresh.
// Define AMIGA_DRAM_WPRO_EN to add the _WPRO write-protect input and WPRO_LED output.
module amiga_dram_ctrl #(
  parameter int T_RCD       = 2,
  parameter int T_RP        = 2,
  parameter int T_RAS_REF   = 3,
  parameter int REFRESH_DIV = 112,
  parameter int PEND_MAX    = 7
)(
  input  logic        CLK,
  input  logic        _RST,
  input  logic        SEL,
  input  logic        _AS,
  input  logic        _UDS,
  input  logic        _LDS,
  input  logic        _PRW,
  input  logic [17:1] A,
`ifdef AMIGA_DRAM_WPRO_EN
  input  logic        _WPRO,
  output logic        WPRO_LED,
`endif
  output logic        _DTACK,
  output logic [7:0]  MA,
  output logic        ROWSEL,
  output logic        _RAS,
  output logic [3:0]  _CAS,
  output logic        _WE,
  output logic        _DOE
);

  localparam int DW = $clog2(REFRESH_DIV);
  localparam int PW = $clog2(PEND_MAX + 1);

  typedef enum logic [2:0] {S_IDLE, S_ROW, S_COL, S_ACK, S_PRE, S_REF} state_t;

  state_t          r_state, w_next;
  logic [7:0]      r_cnt;
  logic [7:0]      r_row, r_col, r_ref_row;
  logic            r_bank, r_rd, r_wp;
  logic [3:0]      r_cas_n;
  logic            r_dtack_n;
  logic [DW-1:0]   r_div;
  logic [PW-1:0]   r_pend;
  logic            w_tick, w_ref_done, w_wp_req;
  logic [3:0]      w_cas_hit;

`ifdef AMIGA_DRAM_WPRO_EN
  assign WPRO_LED = _WPRO;
  assign w_wp_req = ~_WPRO;
`else
  assign w_wp_req = 1'b0;
`endif

  // Strobes land on the half of the CAS vector selected by the latched bank bit.
  assign w_cas_hit  = r_bank ? {~_UDS, ~_LDS, 2'b00} : {2'b00, ~_UDS, ~_LDS};
  assign w_tick     = (r_div == DW'(REFRESH_DIV - 1));
  assign w_ref_done = (r_state == S_REF) && (r_cnt == 8'(T_RAS_REF - 1));

  // State register
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
    end
  end

  // Next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (r_pend != '0)            w_next = S_REF;
              else if (!_AS && SEL)        w_next = S_ROW;
      S_ROW:  if (_AS)                     w_next = S_PRE;
              else if (r_cnt == 8'(T_RCD - 1)) w_next = S_COL;
      S_COL:  if (_AS)                     w_next = S_PRE;
              else if (|w_cas_hit)         w_next = S_ACK;
      S_ACK:  if (_AS)                     w_next = S_PRE;
      S_PRE:  if (r_cnt == 8'(T_RP - 1))   w_next = S_IDLE;
      S_REF:  if (w_ref_done)              w_next = S_PRE;
      default:                             w_next = S_IDLE;
    endcase
  end

  // Access latches, CAS/DTACK registers
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      r_row     <= '0;
      r_col     <= '0;
      r_bank    <= 1'b0;
      r_rd      <= 1'b1;
      r_wp      <= 1'b0;
      r_cas_n   <= 4'hF;
      r_dtack_n <= 1'b1;
    end else begin
      if (r_state == S_IDLE && w_next == S_ROW) begin
        r_row  <= A[16:9];
        r_col  <= A[8:1];
        r_bank <= A[17];
        r_rd   <= _PRW;
        r_wp   <= ~_PRW & w_wp_req;
      end
      // CAS bits only ever fall while the access continues; a protected write keeps them high.
      if (w_next == S_ACK) begin
        if (!r_wp) r_cas_n <= r_cas_n & ~w_cas_hit;
      end else begin
        r_cas_n <= 4'hF;
      end
      r_dtack_n <= ~((r_state == S_ACK) && (w_next == S_ACK));
    end
  end

  // Refresh row counter, divider and pending-request counter
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      r_ref_row <= '0;
      r_div     <= '0;
      r_pend    <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (w_ref_done) r_ref_row <= r_ref_row + 8'd1;
      if (w_tick && !w_ref_done && r_pend != PW'(PEND_MAX))
        r_pend <= r_pend + 1'b1;
      else if (!w_tick && w_ref_done)
        r_pend <= r_pend - 1'b1;
    end
  end

  // Outputs
  always_comb begin
    _RAS   = 1'b1;
    ROWSEL = 1'b1;
    MA     = 8'h00;
    _WE    = 1'b1;
    _DOE   = 1'b1;
    unique case (r_state)
      S_ROW: begin
        _RAS = 1'b0;
        MA   = r_row;
        _WE  = r_rd | r_wp;
      end
      S_COL: begin
        _RAS   = 1'b0;
        ROWSEL = 1'b0;
        MA     = r_col;
        _WE    = r_rd | r_wp;
      end
      S_ACK: begin
        _RAS   = 1'b0;
        ROWSEL = 1'b0;
        MA     = r_col;
        _WE    = r_rd | r_wp;
        _DOE   = ~r_rd;
      end
      S_REF: begin
        _RAS = 1'b0;
        MA   = r_ref_row;
      end
      default: ;
    endcase
    _CAS   = r_cas_n;
    _DTACK = r_dtack_n;
  end

endmodule
